// File: rtl/ram_pkg.sv
// ram_pkg
// Shared definitions for the RAM burst sequencer and anything that talks
// to single_port_ram: default geometry, the sequencer FSM state type and
// the RAM direction encoding.
//
// Contents:
//   DATA_W_DEF / DEPTH_DEF / ADDR_W_DEF  default RAM geometry
//   state_t                              burst FSM states
//   WR / RD                              values driven on ram_wrd
//   len_legal()                          burst length range check
package ram_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int DEPTH_DEF  = 16;
   localparam int ADDR_W_DEF = 4;

   // IDLE waits for a command, WRITE/READ issue one RAM access per
   // accepted beat, DRAIN lets the final read beat come back from the RAM.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   localparam logic WR = 1'b1;
   localparam logic RD = 1'b0;

   // A burst must move at least one word and may not revisit a word,
   // so the legal range is 1..depth inclusive.
   function automatic logic len_legal(input int unsigned len,
                                      input int unsigned depth);
      return (len != 0) && (len <= depth);
   endfunction

endpackage

// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl
// Command-driven burst sequencer that sits directly in front of
// single_port_ram and is the only driver of its access pins. One command
// (start address, length, direction) is taken at a time; write bursts pull
// beats from a producer, read bursts push RAM data to a consumer.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cmd_valid/cmd_ready       command handshake
//   cmd_wr, cmd_addr, cmd_len burst direction, start address, beat count
//   wr_valid/wr_ready/wr_data write beat stream in
//   rd_valid/rd_data          read beat stream out (no backpressure)
//   busy                      burst in progress
//   err                       one-cycle pulse after an illegal length
//   ram_valid/ram_wrd         RAM access strobe and direction
//   ram_address/ram_wdata     RAM address and write data
//   ram_rdata                 RAM read data, one cycle after the access
//   ram_ready                 RAM out of reset and accepting accesses
module ram_burst_ctrl
   import ram_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_wr,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [ADDR_W:0]   cmd_len,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              err,
   output logic              ram_valid,
   output logic              ram_wrd,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   input  logic              ram_ready
);

   state_t            state;
   logic [ADDR_W-1:0] cur_addr;
   logic [ADDR_W:0]   remaining;
   logic              pending;

   logic              cmd_fire;
   logic              cmd_ok;
   logic              write_beat;
   logic              read_access;
   logic              last_beat;
   logic [ADDR_W-1:0] next_addr;

   // Address arithmetic relies on DEPTH being exactly 2**ADDR_W so the
   // natural ADDR_W-bit rollover is the wrap back to word 0.
   assign next_addr = cur_addr + ADDR_W'(1);
   assign last_beat = (remaining == (ADDR_W+1)'(1));
   assign cmd_ok    = len_legal(int'(cmd_len), DEPTH);

   // The RAM pins follow the handshakes in the same cycle, so a write beat
   // costs no extra latency and ram_ready gates every access directly.
   // All RAM pins stay at zero outside an access so ram_wrd never hangs
   // high on an idle bus.
   always_comb begin
      cmd_ready   = 1'b0;
      wr_ready    = 1'b0;
      write_beat  = 1'b0;
      read_access = 1'b0;
      ram_valid   = 1'b0;
      ram_wrd     = RD;
      ram_address = '0;
      ram_wdata   = '0;
      case (state)
         IDLE: begin
            cmd_ready = ram_ready;
         end
         WRITE: begin
            wr_ready = ram_ready;
            if (wr_valid && ram_ready) begin
               write_beat  = 1'b1;
               ram_valid   = 1'b1;
               ram_wrd     = WR;
               ram_address = cur_addr;
               ram_wdata   = wr_data;
            end
         end
         READ: begin
            if (ram_ready) begin
               read_access = 1'b1;
               ram_valid   = 1'b1;
               ram_wrd     = RD;
               ram_address = cur_addr;
            end
         end
         default: begin
         end
      endcase
   end

   assign cmd_fire = cmd_valid && cmd_ready;

   // The RAM returns read data one cycle after the access, so the pending
   // flag marks exactly the cycles in which ram_rdata is a real beat.
   // Masking rd_data keeps the consumer bus at zero between beats.
   assign rd_valid = pending;
   assign rd_data  = pending ? ram_rdata : '0;
   assign busy     = (state != IDLE);

   // Burst sequencer. A stalled RAM simply freezes address and count, so
   // the burst resumes where it left off. Clearing pending on reset is
   // what drops any read beat still in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cur_addr  <= '0;
         remaining <= '0;
         pending   <= 1'b0;
         err       <= 1'b0;
      end else begin
         err     <= 1'b0;
         pending <= read_access;
         case (state)
            IDLE: begin
               if (cmd_fire) begin
                  if (cmd_ok) begin
                     cur_addr  <= cmd_addr;
                     remaining <= cmd_len;
                     state     <= (cmd_wr == WR) ? WRITE : READ;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            WRITE: begin
               if (write_beat) begin
                  cur_addr  <= next_addr;
                  remaining <= remaining - (ADDR_W+1)'(1);
                  if (last_beat) begin
                     state <= IDLE;
                  end
               end
            end
            READ: begin
               if (read_access) begin
                  cur_addr  <= next_addr;
                  remaining <= remaining - (ADDR_W+1)'(1);
                  if (last_beat) begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// tb_ram_burst_ctrl
// Directed bench for ram_burst_ctrl. A small behavioural single-port RAM
// (write on access, registered read data one cycle later) sits beside the
// controller so write bursts can be read back through the controller.
module tb_ram_burst_ctrl;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_wr;
   logic [ADDR_W-1:0] cmd_addr;
   logic [ADDR_W:0]   cmd_len;
   logic              wr_valid;
   logic              wr_ready;
   logic [DATA_W-1:0] wr_data;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic              busy;
   logic              err;
   logic              ram_valid;
   logic              ram_wrd;
   logic [ADDR_W-1:0] ram_address;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;
   logic              ram_ready;

   int checks = 0;
   int fails  = 0;

   logic [DATA_W-1:0] mem [DEPTH];

   always #5 clk = ~clk;

   ram_burst_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_data(rd_data),
      .busy(busy), .err(err),
      .ram_valid(ram_valid), .ram_wrd(ram_wrd), .ram_address(ram_address),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ready(ram_ready)
   );

   // Stand-in for single_port_ram: writes land at the edge, reads return
   // on ram_rdata during the following cycle.
   always @(posedge clk) begin
      if (ram_valid && ram_wrd)
         mem[ram_address] <= ram_wdata;
      if (ram_valid && !ram_wrd)
         ram_rdata <= mem[ram_address];
   end

   // Advance to just after the next rising edge, where inputs are driven.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer a command for one cycle; the controller must be idle.
   task automatic send_cmd(input logic wr, input logic [3:0] addr, input logic [4:0] len);
      cmd_valid = 1'b1;
      cmd_wr    = wr;
      cmd_addr  = addr;
      cmd_len   = len;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
      wr_valid = 1'b0; wr_data = '0; ram_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if ({busy, err, rd_valid, ram_valid, ram_wrd, wr_ready, ram_address, ram_wdata, rd_data} !== '0) begin
         fails++;
         $display("[TB] FAIL reset_outputs: got busy=%b err=%b rd_valid=%b ram_valid=%b ram_wrd=%b wr_ready=%b addr=%0d wdata=%h rd_data=%h, want all 0",
                  busy, err, rd_valid, ram_valid, ram_wrd, wr_ready, ram_address, ram_wdata, rd_data);
      end
      tick();
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1) begin
         fails++;
         $display("[TB] FAIL idle_cmd_ready: got %b, want 1", cmd_ready);
      end
      ram_ready = 1'b0;
      #1;
      checks++;
      if (cmd_ready !== 1'b0) begin
         fails++;
         $display("[TB] FAIL cmd_ready_ram_not_ready: got %b, want 0", cmd_ready);
      end
      ram_ready = 1'b1;
      tick();
   endtask

   // Write burst with wr_valid held high; beat i carries base+i.
   task automatic test_write_burst(input logic [3:0] start, input int len, input logic [7:0] base);
      logic [3:0] a;
      logic [7:0] d;
      send_cmd(1'b1, start, 5'(len));
      for (int i = 0; i < len; i++) begin
         a = 4'(start + 4'(i));
         d = 8'(base + 8'(i));
         wr_valid = 1'b1;
         wr_data  = d;
         @(negedge clk);
         checks++;
         if ({busy, wr_ready, ram_valid, ram_wrd, ram_address, ram_wdata} !== {1'b1, 1'b1, 1'b1, 1'b1, a, d}) begin
            fails++;
            $display("[TB] FAIL write_beat_%0d: got busy=%b wr_ready=%b valid=%b wrd=%b addr=%0d wdata=%h, want 1 1 1 1 %0d %h",
                     i, busy, wr_ready, ram_valid, ram_wrd, ram_address, ram_wdata, a, d);
         end
         tick();
      end
      wr_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, ram_valid} !== 2'b00) begin
         fails++;
         $display("[TB] FAIL write_end: got busy=%b ram_valid=%b, want 0 0", busy, ram_valid);
      end
      tick();
   endtask

   // Read burst; expects data base+k from address start+k, one cycle late.
   task automatic test_read_burst(input logic [3:0] start, input int len, input logic [7:0] base);
      logic [3:0] a;
      logic [8:0] exp_rd;
      send_cmd(1'b0, start, 5'(len));
      for (int k = 0; k <= len; k++) begin
         a = 4'(start + 4'(k));
         exp_rd = (k > 0) ? {1'b1, 8'(base + 8'(k - 1))} : 9'h000;
         @(negedge clk);
         if (k < len) begin
            checks++;
            if ({ram_valid, ram_wrd, ram_address} !== {1'b1, 1'b0, a}) begin
               fails++;
               $display("[TB] FAIL read_access_%0d: got valid=%b wrd=%b addr=%0d, want 1 0 %0d",
                        k, ram_valid, ram_wrd, ram_address, a);
            end
         end else begin
            checks++;
            if ({busy, ram_valid} !== 2'b10) begin
               fails++;
               $display("[TB] FAIL read_drain: got busy=%b ram_valid=%b, want 1 0", busy, ram_valid);
            end
         end
         checks++;
         if ({rd_valid, rd_data} !== exp_rd) begin
            fails++;
            $display("[TB] FAIL read_beat_%0d: got rd_valid=%b rd_data=%h, want %b %h",
                     k, rd_valid, rd_data, exp_rd[8], exp_rd[7:0]);
         end
         tick();
      end
      @(negedge clk);
      checks++;
      if ({busy, rd_valid, cmd_ready} !== 3'b001) begin
         fails++;
         $display("[TB] FAIL read_end: got busy=%b rd_valid=%b cmd_ready=%b, want 0 0 1", busy, rd_valid, cmd_ready);
      end
      tick();
   endtask

   // Write of 3 beats to address 5 with wr_valid pattern 1,0,1,0,1.
   task automatic test_gap_write();
      logic [4:0] pattern;
      int         beat;
      pattern = 5'b10101;
      beat = 0;
      send_cmd(1'b1, 4'd5, 5'd3);
      for (int c = 0; c < 5; c++) begin
         wr_valid = pattern[c];
         wr_data  = 8'(8'h50 + 8'(beat));
         @(negedge clk);
         checks++;
         if (pattern[c]) begin
            if ({ram_valid, ram_wrd, ram_address, ram_wdata} !== {1'b1, 1'b1, 4'(4'd5 + 4'(beat)), wr_data}) begin
               fails++;
               $display("[TB] FAIL gap_write_cycle_%0d: got valid=%b wrd=%b addr=%0d wdata=%h, want 1 1 %0d %h",
                        c, ram_valid, ram_wrd, ram_address, ram_wdata, 4'(4'd5 + 4'(beat)), wr_data);
            end
            beat++;
         end else begin
            if ({ram_valid, ram_wrd, busy} !== 3'b001) begin
               fails++;
               $display("[TB] FAIL gap_idle_cycle_%0d: got valid=%b wrd=%b busy=%b, want 0 0 1", c, ram_valid, ram_wrd, busy);
            end
         end
         tick();
      end
      wr_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         fails++;
         $display("[TB] FAIL gap_write_done: got busy=%b, want 0", busy);
      end
      tick();
      test_read_burst(4'd5, 3, 8'h50);
   endtask

   task automatic test_illegal_len(input logic [4:0] len);
      cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 4'd3; cmd_len = len;
      @(negedge clk);
      checks++;
      if ({cmd_ready, ram_valid, err} !== 3'b100) begin
         fails++;
         $display("[TB] FAIL illegal_offer_len%0d: got cmd_ready=%b ram_valid=%b err=%b, want 1 0 0", len, cmd_ready, ram_valid, err);
      end
      tick();
      cmd_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({err, busy, ram_valid, cmd_ready} !== 4'b1001) begin
         fails++;
         $display("[TB] FAIL illegal_err_len%0d: got err=%b busy=%b ram_valid=%b cmd_ready=%b, want 1 0 0 1",
                  len, err, busy, ram_valid, cmd_ready);
      end
      tick();
      @(negedge clk);
      checks++;
      if ({err, busy} !== 2'b00) begin
         fails++;
         $display("[TB] FAIL illegal_err_clear_len%0d: got err=%b busy=%b, want 0 0", len, err, busy);
      end
      tick();
   endtask

   // ram_ready drops for one cycle in a write and in a read burst.
   task automatic test_ram_stall();
      send_cmd(1'b1, 4'd10, 5'd3);
      wr_valid = 1'b1; wr_data = 8'hD0;
      tick();
      ram_ready = 1'b0; wr_data = 8'hD1;
      @(negedge clk);
      checks++;
      if ({wr_ready, ram_valid, busy} !== 3'b001) begin
         fails++;
         $display("[TB] FAIL stall_write: got wr_ready=%b ram_valid=%b busy=%b, want 0 0 1", wr_ready, ram_valid, busy);
      end
      tick();
      ram_ready = 1'b1;
      @(negedge clk);
      checks++;
      if ({ram_valid, ram_address, ram_wdata} !== {1'b1, 4'd11, 8'hD1}) begin
         fails++;
         $display("[TB] FAIL stall_write_resume: got valid=%b addr=%0d wdata=%h, want 1 11 d1", ram_valid, ram_address, ram_wdata);
      end
      tick();
      wr_data = 8'hD2;
      tick();
      wr_valid = 1'b0;
      send_cmd(1'b0, 4'd10, 5'd3);
      tick();
      ram_ready = 1'b0;
      @(negedge clk);
      checks++;
      if ({ram_valid, rd_valid, rd_data} !== {1'b0, 1'b1, 8'hD0}) begin
         fails++;
         $display("[TB] FAIL stall_read_pending: got ram_valid=%b rd_valid=%b rd_data=%h, want 0 1 d0", ram_valid, rd_valid, rd_data);
      end
      tick();
      ram_ready = 1'b1;
      @(negedge clk);
      checks++;
      if ({ram_valid, ram_address, rd_valid} !== {1'b1, 4'd11, 1'b0}) begin
         fails++;
         $display("[TB] FAIL stall_read_resume: got valid=%b addr=%0d rd_valid=%b, want 1 11 0", ram_valid, ram_address, rd_valid);
      end
      repeat (3) tick();
      @(negedge clk);
      checks++;
      if ({busy, rd_valid} !== 2'b00) begin
         fails++;
         $display("[TB] FAIL stall_read_end: got busy=%b rd_valid=%b, want 0 0", busy, rd_valid);
      end
      tick();
   endtask

   // A command offered during DRAIN must wait, then be taken in IDLE.
   task automatic test_back_to_back();
      send_cmd(1'b0, 4'd10, 5'd1);
      tick();
      cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 4'd11; cmd_len = 5'd1;
      @(negedge clk);
      checks++;
      if ({busy, cmd_ready, rd_valid, rd_data} !== {1'b1, 1'b0, 1'b1, 8'hD0}) begin
         fails++;
         $display("[TB] FAIL b2b_drain: got busy=%b cmd_ready=%b rd_valid=%b rd_data=%h, want 1 0 1 d0",
                  busy, cmd_ready, rd_valid, rd_data);
      end
      tick();
      @(negedge clk);
      checks++;
      if ({busy, cmd_ready} !== 2'b01) begin
         fails++;
         $display("[TB] FAIL b2b_idle_accept: got busy=%b cmd_ready=%b, want 0 1", busy, cmd_ready);
      end
      tick();
      cmd_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, ram_valid, ram_wrd, ram_address} !== {1'b1, 1'b1, 1'b0, 4'd11}) begin
         fails++;
         $display("[TB] FAIL b2b_second_access: got busy=%b valid=%b wrd=%b addr=%0d, want 1 1 0 11",
                  busy, ram_valid, ram_wrd, ram_address);
      end
      tick();
      @(negedge clk);
      checks++;
      if ({rd_valid, rd_data} !== {1'b1, 8'hD1}) begin
         fails++;
         $display("[TB] FAIL b2b_second_beat: got rd_valid=%b rd_data=%h, want 1 d1", rd_valid, rd_data);
      end
      repeat (2) tick();
   endtask

   task automatic test_reset_mid_read();
      int extra;
      send_cmd(1'b0, 4'd0, 5'd8);
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, err, rd_valid, ram_valid, ram_wrd, wr_ready, ram_address, ram_wdata, rd_data} !== '0) begin
         fails++;
         $display("[TB] FAIL mid_reset_outputs: got busy=%b err=%b rd_valid=%b ram_valid=%b ram_wrd=%b wr_ready=%b addr=%0d wdata=%h rd_data=%h, want all 0",
                  busy, err, rd_valid, ram_valid, ram_wrd, wr_ready, ram_address, ram_wdata, rd_data);
      end
      extra = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (rd_valid === 1'b1 || ram_valid === 1'b1) extra++;
         tick();
      end
      checks++;
      if (extra != 0) begin
         fails++;
         $display("[TB] FAIL mid_reset_no_activity: got %0d active cycles, want 0", extra);
      end
      test_write_burst(4'd8, 4, 8'hC0);
      test_read_burst(4'd8, 4, 8'hC0);
   endtask

   initial begin
      $display("[TB] start");
      test_reset();
      test_write_burst(4'd0, 16, 8'h10);
      test_read_burst(4'd0, 16, 8'h10);
      test_write_burst(4'd14, 4, 8'hA0);
      test_read_burst(4'd14, 4, 8'hA0);
      test_gap_write();
      test_illegal_len(5'd0);
      test_illegal_len(5'd17);
      test_ram_stall();
      test_back_to_back();
      test_reset_mid_read();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
